chess_turn_ctrl: RTL and testbench

Front-end control stage for the chess clock: synchronizes and debounces the five player push-buttons, runs the game state machine (idle / player-1 running / player-2 running / paused / over), and generates the one-second enable pulse for the active player's timer. Sits directly upstream of the per-player BCD timer/display stage. Outputs drive that stage's count enable and turn select. It consumes the timer stage's timeout flags.

---
 rtl/chess_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/chess_turn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_chess_turn_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess clock types: game states and winner codes.
// Used by the turn control stage and the BCD timer stage.
package chess_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_P1,
    RUN_P2,
    PAUSE,
    OVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic is_run(state_t s);
    return (s == RUN_P1) || (s == RUN_P2);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: 2-flop sync, stability debounce, press pulse.
// Ports: clk, reset_n, btn (raw) -> press (one-cycle, registered).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          lvl;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_d <= lvl;
      press <= lvl & ~lvl_d;
      // any return to the accepted level restarts the stability count
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock turn control: button front ends, game FSM, 1 s tick.
// Ports: 5 raw buttons, 2 timeout flags in; tick/turn/status out.
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       switch_p1_btn,
  input  logic       switch_p2_btn,
  input  logic       surrender_p1_btn,
  input  logic       surrender_p2_btn,
  input  logic       timeout_p1,
  input  logic       timeout_p2,
  output logic       sec_tick,
  output logic       active_player,
  output logic       running,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  logic start_press;
  logic sw1_press;
  logic sw2_press;
  logic sur1_press;
  logic sur2_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk(clk), .reset_n(reset_n),
    .btn(start_btn), .press(start_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .clk(clk), .reset_n(reset_n),
    .btn(switch_p1_btn), .press(sw1_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
    .clk(clk), .reset_n(reset_n),
    .btn(switch_p2_btn), .press(sw2_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sur1 (
    .clk(clk), .reset_n(reset_n),
    .btn(surrender_p1_btn), .press(sur1_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sur2 (
    .clk(clk), .reset_n(reset_n),
    .btn(surrender_p2_btn), .press(sur2_press)
  );

  state_t        state_q, state_d;
  logic          act_q, act_d;
  logic [1:0]    win_q, win_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          run_q, run_d;
  logic          over_q, over_d;

  logic       own_sw;
  logic       own_tmo;
  logic       any_sur;
  logic [1:0] sur_win;

  assign own_sw  = act_q ? sw2_press : sw1_press;
  assign own_tmo = act_q ? timeout_p2 : timeout_p1;
  assign any_sur = sur1_press | sur2_press;

  always_comb begin
    sur_win = WIN_P1;
    unique case (1'b1)
      sur1_press & sur2_press: sur_win = WIN_DRAW;
      sur1_press & ~sur2_press: sur_win = WIN_P2;
      default: sur_win = WIN_P1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      act_q   <= 1'b0;
      win_q   <= WIN_NONE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      win_q   <= win_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    win_d   = win_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_press) begin
          state_d = RUN_P1;
          act_d   = 1'b0;
          presc_d = '0;
        end
      end
      RUN_P1, RUN_P2: begin
        // leaving RUN never counts, so the tick is suppressed
        if (own_tmo) begin
          state_d = OVER;
          win_d   = act_q ? WIN_P1 : WIN_P2;
        end else if (any_sur) begin
          state_d = OVER;
          win_d   = sur_win;
        end else if (start_press) begin
          state_d = PAUSE;
        end else if (own_sw) begin
          state_d = act_q ? RUN_P1 : RUN_P2;
          act_d   = ~act_q;
          presc_d = '0;
        end else if (presc_q == PMAX) begin
          presc_d = '0;
          tick_d  = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        // prescaler held so the partial second carries over
        if (any_sur) begin
          state_d = OVER;
          win_d   = sur_win;
        end else if (start_press) begin
          state_d = act_q ? RUN_P2 : RUN_P1;
        end
      end
      OVER: begin
        if (start_press) begin
          state_d = IDLE;
          act_d   = 1'b0;
          win_d   = WIN_NONE;
          presc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_d  = is_run(state_d);
    over_d = (state_d == OVER);
  end

  assign sec_tick      = tick_q;
  assign active_player = act_q;
  assign running       = run_q;
  assign game_over     = over_q;
  assign winner        = win_q;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench for chess_turn_ctrl (CLK_HZ=10, DEBOUNCE=4).
// Stimulus queues expected output events; a monitor checks them.
module tb_chess_turn_ctrl;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] btn = '0;
  logic       to1 = 1'b0;
  logic       to2 = 1'b0;
  logic       sec_tick;
  logic       active_player;
  logic       running;
  logic       game_over;
  logic [1:0] winner;

  chess_turn_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_btn(btn[0]),
    .switch_p1_btn(btn[1]),
    .switch_p2_btn(btn[2]),
    .surrender_p1_btn(btn[3]),
    .surrender_p2_btn(btn[4]),
    .timeout_p1(to1),
    .timeout_p2(to2),
    .sec_tick(sec_tick),
    .active_player(active_player),
    .running(running),
    .game_over(game_over),
    .winner(winner)
  );

  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_SW1   = 5'b00010;
  localparam logic [4:0] B_SW2   = 5'b00100;
  localparam logic [4:0] B_SUR1  = 5'b01000;
  localparam logic [4:0] B_SUR2  = 5'b10000;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic       run;
    logic       act;
    logic       over;
    logic [1:0] win;
    logic       tick;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;

  bit         seg_on = 1'b0;
  int         next_tick = 0;
  int         rem = 0;
  logic       e_run = 1'b0;
  logic       e_act = 1'b0;
  logic       e_over = 1'b0;
  logic [1:0] e_win = WIN_NONE;

  task automatic push(int at, logic tk);
    ev_t e;
    e.cyc  = at;
    e.run  = e_run;
    e.act  = e_act;
    e.over = e_over;
    e.win  = e_win;
    e.tick = tk;
    q.push_back(e);
  endtask

  task automatic push_ticks_until(int lim);
    while (seg_on && next_tick < lim) begin
      push(next_tick, 1'b1);
      next_tick += 10;
    end
  endtask

  task automatic wait_cyc(int n);
    push_ticks_until(cyc + n + 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic change(int at, logic r, logic a, logic o,
                        logic [1:0] w);
    push_ticks_until(at);
    e_run  = r;
    e_act  = a;
    e_over = o;
    e_win  = w;
    push(at, 1'b0);
  endtask

  task automatic enter_run(int at, logic a);
    change(at, 1'b1, a, 1'b0, WIN_NONE);
    seg_on    = 1'b1;
    next_tick = at + 10;
  endtask

  task automatic pause_at(int at);
    change(at, 1'b0, e_act, 1'b0, WIN_NONE);
    rem    = next_tick - at + 1;
    seg_on = 1'b0;
  endtask

  task automatic resume_at(int at);
    change(at, 1'b1, e_act, 1'b0, WIN_NONE);
    seg_on    = 1'b1;
    next_tick = at + rem;
  endtask

  task automatic finish_at(int at, logic [1:0] w);
    change(at, 1'b0, e_act, 1'b1, w);
    seg_on = 1'b0;
  endtask

  task automatic tap(logic [4:0] m, int hold);
    btn = btn | m;
    wait_cyc(hold);
    btn = btn & ~m;
    wait_cyc(12);
  endtask

  bit   mon_en = 1'b1;
  bit   first = 1'b1;
  logic [4:0] last = '0;
  ev_t  got;
  ev_t  want;

  always @(negedge clk) begin
    if (mon_en) begin
      got.cyc  = cyc;
      got.run  = running;
      got.act  = active_player;
      got.over = game_over;
      got.win  = winner;
      got.tick = sec_tick;
      if (first || sec_tick ||
          {running, active_player, game_over, winner} != last) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got cyc=%0d run=%b act=%b over=%b win=%b tick=%b required none",
                   got.cyc, got.run, got.act, got.over, got.win, got.tick);
        end else begin
          want = q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL event got cyc=%0d run=%b act=%b over=%b win=%b tick=%b required cyc=%0d run=%b act=%b over=%b win=%b tick=%b",
                     got.cyc, got.run, got.act, got.over, got.win, got.tick,
                     want.cyc, want.run, want.act, want.over, want.win, want.tick);
          end
        end
      end
      first = 1'b0;
      last  = {running, active_player, game_over, winner};
    end
  end

  int t;
  int c;
  ev_t left;

  initial begin
    push(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    tap(B_SW1, 6);
    tap(B_SUR1 | B_SUR2, 6);

    enter_run(cyc + 8, 1'b0);
    tap(B_START, 6);
    wait_cyc(15);

    tap(B_SW2, 6);
    enter_run(cyc + 8, 1'b1);
    tap(B_SW1, 6);

    t = next_tick - 11;
    while (t < cyc) t += 10;
    wait_cyc(t - cyc);
    pause_at(cyc + 8);
    tap(B_START, 6);
    wait_cyc(10);
    resume_at(cyc + 8);
    tap(B_START, 6);
    wait_cyc(5);

    enter_run(cyc + 8, 1'b0);
    tap(B_SW2, 6);
    repeat (3) begin
      btn[1] = 1'b1;
      wait_cyc(3);
      btn[1] = 1'b0;
      wait_cyc(3);
    end
    wait_cyc(6);
    enter_run(cyc + 8, 1'b1);
    tap(B_SW1, 5);

    enter_run(cyc + 8, 1'b0);
    tap(B_SW2, 6);
    to2 = 1'b1;
    wait_cyc(3);
    to2 = 1'b0;
    wait_cyc(2);

    c = cyc;
    btn[4] = 1'b1;
    finish_at(c + 8, WIN_P2);
    wait_cyc(7);
    to1 = 1'b1;
    wait_cyc(1);
    to1 = 1'b0;
    wait_cyc(4);
    btn[4] = 1'b0;
    wait_cyc(12);

    tap(B_SW1, 6);
    change(cyc + 8, 1'b0, 1'b0, 1'b0, WIN_NONE);
    tap(B_START, 6);

    enter_run(cyc + 8, 1'b0);
    tap(B_START, 6);
    enter_run(cyc + 8, 1'b1);
    tap(B_SW1, 6);
    pause_at(cyc + 8);
    tap(B_START, 6);
    finish_at(cyc + 8, WIN_DRAW);
    tap(B_SUR1 | B_SUR2, 6);
    change(cyc + 8, 1'b0, 1'b0, 1'b0, WIN_NONE);
    tap(B_START, 6);

    enter_run(cyc + 8, 1'b0);
    tap(B_START, 6);
    enter_run(cyc + 8, 1'b1);
    tap(B_SW1, 6);
    t = next_tick - 5;
    while (t < cyc) t += 10;
    wait_cyc(t - cyc);
    change(cyc, 1'b0, 1'b0, 1'b0, WIN_NONE);
    seg_on = 1'b0;
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    wait_cyc(2);

    enter_run(cyc + 8, 1'b0);
    tap(B_START, 6);
    wait_cyc(12);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    while (q.size() > 0) begin
      left = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event got none required cyc=%0d run=%b act=%b over=%b win=%b tick=%b",
               left.cyc, left.run, left.act, left.over, left.win, left.tick);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
